// File: rtl/bp_noc_edge_gate.sv
// Packet-aware edge gate: per-channel two-entry FIFOs with wormhole trackers that
// close the input side only at packet boundaries while quiesce_i is held.
module bp_noc_edge_gate #(
  parameter int channels_p   = 5,
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int len_offset_p = 0
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [channels_p-1:0]                in_v_i,
  input  logic [channels_p*flit_width_p-1:0]   in_data_i,
  output logic [channels_p-1:0]                in_ready_and_o,
  output logic [channels_p-1:0]                out_v_o,
  output logic [channels_p*flit_width_p-1:0]   out_data_o,
  input  logic [channels_p-1:0]                out_ready_and_i,
  input  logic                                 quiesce_i,
  output logic                                 quiesced_o
);

  typedef enum logic {HEAD, BODY} state_e;

  localparam logic [len_width_p-1:0] LenOne = len_width_p'(1);

  // Holds all input gates closed during reset and opens them on the first edge after.
  logic rdy_en_q, rdy_en_d;
  logic [channels_p-1:0] at_head;
  logic [channels_p-1:0] fifo_empty;

  always_comb begin
    rdy_en_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rdy_en_q <= 1'b0;
    else            rdy_en_q <= rdy_en_d;
  end

  assign quiesced_o = quiesce_i & (&at_head) & (&fifo_empty);

  for (genvar c = 0; c < channels_p; c++) begin : g_ch
    logic [flit_width_p-1:0] mem_q [2];
    logic [flit_width_p-1:0] mem_d [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              cnt_q, cnt_d;
    state_e                  state_q, state_d;
    logic [len_width_p-1:0]  rem_q, rem_d;
    logic [flit_width_p-1:0] flit;
    logic [len_width_p-1:0]  hdr_len;
    logic                    push, pop, not_full;

    assign flit    = in_data_i[c*flit_width_p +: flit_width_p];
    assign hdr_len = flit[len_offset_p +: len_width_p];

    // Ready looks only at registered state, so a full FIFO refuses even when popping.
    assign not_full          = (cnt_q != 2'd2);
    assign in_ready_and_o[c] = rdy_en_q & not_full & ((state_q == BODY) | ~quiesce_i);
    assign push              = in_v_i[c] & in_ready_and_o[c];

    assign out_v_o[c]        = (cnt_q != 2'd0);
    assign pop               = out_v_o[c] & out_ready_and_i[c];
    assign out_data_o[c*flit_width_p +: flit_width_p] = mem_q[rd_ptr_q];

    assign at_head[c]    = (state_q == HEAD);
    assign fifo_empty[c] = (cnt_q == 2'd0);

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
        mem_d[wr_ptr_q] = flit;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (push) begin
        if (state_q == HEAD) begin
          if (hdr_len != '0) begin
            state_d = BODY;
            rem_d   = hdr_len;
          end
        end else begin
          rem_d = rem_q - LenOne;
          if (rem_q == LenOne) state_d = HEAD;
        end
      end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
        cnt_q    <= 2'd0;
        state_q  <= HEAD;
        rem_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        state_q  <= state_d;
        rem_q    <= rem_d;
      end
    end

    always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_bp_noc_edge_gate.sv
// Directed bench for bp_noc_edge_gate with the length field placed at bit 8.
module tb_bp_noc_edge_gate;
  localparam int CH = 5;
  localparam int FW = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     in_v;
  logic [CH*FW-1:0]  in_data;
  logic [CH-1:0]     in_ready;
  logic [CH-1:0]     out_v;
  logic [CH*FW-1:0]  out_data;
  logic [CH-1:0]     out_ready;
  logic              quiesce;
  logic              quiesced;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bp_noc_edge_gate #(
    .channels_p(CH), .flit_width_p(FW), .len_width_p(4), .len_offset_p(8)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .in_v_i(in_v), .in_data_i(in_data), .in_ready_and_o(in_ready),
    .out_v_o(out_v), .out_data_o(out_data), .out_ready_and_i(out_ready),
    .quiesce_i(quiesce), .quiesced_o(quiesced)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Header/body flit: id in the upper word, len nibble at bits [11:8], decoy nibble at [3:0].
  function automatic logic [63:0] mk(input int id, input int len);
    return (64'(id) << 32) | (64'(len & 15) << 8) | 64'h2;
  endfunction

  function automatic logic [63:0] od(input int c);
    return out_data[c*FW +: FW];
  endfunction

  task automatic set_in(input int c, input logic [63:0] v);
    in_data[c*FW +: FW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] f [16];

  initial begin
    rst_n = 1'b0; in_v = '0; in_data = '0; out_ready = '0; quiesce = 1'b0;
    #2;
    // Reset state
    chk("rst_out_v", 64'(out_v), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_quiesced_lo", 64'(quiesced), 64'h0);
    quiesce = 1'b1; #1;
    chk("rst_quiesced_hi", 64'(quiesced), 64'h1);
    quiesce = 1'b0;
    tick();
    chk("rst_held_ready", 64'(in_ready), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'h1f);

    // Streaming: header len=3 then 3 bodies on channel 0
    out_ready = '1;
    f[0] = mk(100, 3); f[1] = mk(101, 9); f[2] = mk(102, 0); f[3] = mk(103, 7);
    for (int i = 0; i < 5; i++) begin
      in_v[0] = (i < 4);
      if (i < 4) set_in(0, f[i]);
      #1;
      if (i < 4) chk($sformatf("stream_ready%0d", i), 64'(in_ready[0]), 64'h1);
      if (i > 0) begin
        chk($sformatf("stream_v%0d", i), 64'(out_v[0]), 64'h1);
        chk($sformatf("stream_d%0d", i), od(0), f[i-1]);
      end
      tick();
    end
    chk("stream_idle", 64'(out_v), 64'h0);

    // Backpressure: three single-flit packets with the output stalled
    out_ready = '0;
    f[0] = mk(200, 0); f[1] = mk(201, 0); f[2] = mk(202, 0);
    in_v[0] = 1'b1; set_in(0, f[0]); #1;
    chk("bp_ready0", 64'(in_ready[0]), 64'h1); tick();
    set_in(0, f[1]); #1;
    chk("bp_ready1", 64'(in_ready[0]), 64'h1); tick();
    set_in(0, f[2]); #1;
    chk("bp_full", 64'(in_ready[0]), 64'h0); tick();
    out_ready = '1; #1;
    chk("bp_full_pop", 64'(in_ready[0]), 64'h0);
    chk("bp_d0", od(0), f[0]); tick();
    chk("bp_reopen", 64'(in_ready[0]), 64'h1);
    chk("bp_d1", od(0), f[1]); tick();
    in_v[0] = 1'b0; #1;
    chk("bp_v2", 64'(out_v[0]), 64'h1);
    chk("bp_d2", od(0), f[2]); tick();
    chk("bp_empty", 64'(out_v[0]), 64'h0);

    // Quiesce mid-packet: header len=5, quiesce raised before the bodies
    in_v[0] = 1'b1; set_in(0, mk(300, 5)); #1;
    chk("qm_hdr_ready", 64'(in_ready[0]), 64'h1); tick();
    quiesce = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      f[i] = mk(300 + i, 1);
      set_in(0, f[i]); #1;
      chk($sformatf("qm_body_ready%0d", i), 64'(in_ready[0]), 64'h1);
      chk($sformatf("qm_not_q%0d", i), 64'(quiesced), 64'h0);
      if (i > 1) chk($sformatf("qm_d%0d", i), od(0), f[i-1]);
      tick();
    end
    set_in(0, mk(310, 0)); #1;
    chk("qm_hdr_held", 64'(in_ready), 64'h0);
    chk("qm_last_d", od(0), f[5]);
    chk("qm_draining", 64'(quiesced), 64'h0); tick();
    chk("qm_still_held", 64'(in_ready[0]), 64'h0);
    chk("qm_quiesced", 64'(quiesced), 64'h1);

    // Single-flit headers on all channels while quiesced
    in_v = '1;
    for (int c = 0; c < CH; c++) set_in(c, mk(400 + c, 0));
    #1;
    chk("sf_refused", 64'(in_ready), 64'h0); tick();
    chk("sf_none_out", 64'(out_v), 64'h0);
    quiesce = 1'b0; #1;
    chk("sf_open", 64'(in_ready), 64'h1f);
    chk("sf_q_fall", 64'(quiesced), 64'h0); tick();
    in_v = '0; #1;
    chk("sf_out_v", 64'(out_v), 64'h1f);
    for (int c = 0; c < CH; c++) chk($sformatf("sf_d%0d", c), od(c), mk(400 + c, 0));
    tick();
    chk("sf_drained", 64'(out_v), 64'h0);

    // Length field at offset 8: len=15 keeps channel 1 in BODY for 15 flits
    in_v[1] = 1'b1; set_in(1, mk(500, 15)); #1;
    chk("lf_hdr_ready", 64'(in_ready[1]), 64'h1); tick();
    quiesce = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      set_in(1, mk(500 + i, 0)); #1;
      chk($sformatf("lf_body%0d", i), 64'(in_ready[1]), 64'h1);
      tick();
    end
    set_in(1, mk(520, 0)); #1;
    chk("lf_closed", 64'(in_ready[1]), 64'h0);
    chk("lf_last_d", od(1), mk(515, 0)); tick();
    chk("lf_quiesced", 64'(quiesced), 64'h1);
    in_v = '0; quiesce = 1'b0;

    // Reset mid-packet with two flits buffered on channel 2
    out_ready = '0;
    in_v[2] = 1'b1; set_in(2, mk(600, 4)); tick();
    set_in(2, mk(601, 0)); tick();
    in_v[2] = 1'b0; #1;
    chk("rm_buffered", 64'(out_v), 64'h04);
    #1 rst_n = 1'b0; #1;
    chk("rm_out_v", 64'(out_v), 64'h0);
    chk("rm_in_ready", 64'(in_ready), 64'h0);
    tick();
    rst_n = 1'b1; tick();
    quiesce = 1'b1; #1;
    chk("rm_head_gate", 64'(in_ready[2]), 64'h0);
    chk("rm_quiesced", 64'(quiesced), 64'h1);
    quiesce = 1'b0; out_ready = '1;
    in_v[2] = 1'b1; set_in(2, mk(610, 0)); #1;
    chk("rm_accept", 64'(in_ready[2]), 64'h1); tick();
    in_v[2] = 1'b0; quiesce = 1'b1; #1;
    chk("rm_hdr_single", 64'(in_ready[2]), 64'h0);
    chk("rm_d", od(2), mk(610, 0)); tick();
    chk("rm_final_q", 64'(quiesced), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
